// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulation stage.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_t;

  localparam int MAC_PROD_W  = 48;
  localparam int MAC_ACC_W   = 48;
  localparam int MAC_COUNT_W = 8;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational saturating add/subtract at ACC_W, computed one bit wider so that
// negating the most negative operand cannot wrap before the sum is formed.
module mac_sat_add #(
  parameter int ACC_W = 48
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  input  logic                    sub,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  logic signed [ACC_W:0] a_ext;
  logic signed [ACC_W:0] b_ext;
  logic signed [ACC_W:0] sum_ext;

  function automatic logic signed [ACC_W-1:0] sat_clip(input logic signed [ACC_W:0] x);
    logic signed [ACC_W-1:0] r;
    if (x[ACC_W] != x[ACC_W-1]) begin
      r = x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      r = x[ACC_W-1:0];
    end
    return r;
  endfunction

  always_comb begin
    a_ext   = {a[ACC_W-1], a};
    b_ext   = {b[ACC_W-1], b};
    sum_ext = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    ovf     = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    sum     = sat_clip(sum_ext);
  end

endmodule

// File: rtl/mac_accumulator.sv
// Sequential MAC stage: accumulates LEN signed products (add or subtract) into a
// saturating accumulator and hands the sum out over a valid/ready result port.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W  = MAC_PROD_W,
  parameter int ACC_W   = MAC_ACC_W,
  parameter int COUNT_W = MAC_COUNT_W
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      start,
  input  logic [COUNT_W-1:0]        len,
  input  logic                      sub_mode,
  input  logic                      prod_valid,
  output logic                      prod_ready,
  input  logic signed [PROD_W-1:0]  prod,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [ACC_W-1:0]   res,
  output logic                      res_sat,
  output logic                      busy
);

  mac_state_t state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [COUNT_W-1:0]      cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic                    sub_q, sub_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;

  assign prod_ext = ACC_W'(prod);

  mac_sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sub (sub_q),
    .sum (sum),
    .ovf (ovf)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    sub_d      = sub_q;
    prod_ready = 1'b0;
    res_valid  = 1'b0;
    res        = '0;
    res_sat    = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = len;
          sub_d   = sub_mode;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        prod_ready = 1'b1;
        busy       = 1'b1;
        if (prod_valid) begin
          acc_d = sum;
          sat_d = sat_q | ovf;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == COUNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        res       = acc_q;
        res_sat   = sat_q;
        busy      = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      sub_q   <= sub_d;
    end
  end

endmodule
